pipe_hazard_ctrl: RTL and testbench

//  Drives the en/flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/IF/ID/ID-EX/EX-MEM/MEM-WB enables, flushes and bubbles.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int BOOT_CYC  = 4,
   parameter int FLUSH_CYC = 1,
   parameter int MEM_TO    = 15
`ifdef HAZ_PERF_CNT_EN
   , parameter int CNT_W   = 16
`endif
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs2,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic       mem_access,
   input  logic       dmem_ready,
   input  logic       mem_br_taken,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_en,
   output logic       ex_mem_en,
   output logic       mem_wb_en,
   output logic       pc_sel_br,
   output logic       flush_front,
   output logic       id_ex_bubble,
   output logic       mem_wb_bubble,
   output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt
   , output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
   localparam int WW = $clog2(MEM_TO + 1);
   localparam int FW = $clog2(FLUSH_CYC + 1);

   localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYC - 1);
   localparam logic [WW-1:0] MEM_TO_W   = WW'(MEM_TO);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_br, flush_front, id_ex_bubble, mem_wb_bubble}
   localparam logic [8:0] CTL_OFF = 9'b00000_0000;
   localparam logic [8:0] CTL_RUN = 9'b11111_0000;
   localparam logic [8:0] CTL_MW  = 9'b00001_0001;
   localparam logic [8:0] CTL_LU  = 9'b00111_0010;
   localparam logic [8:0] CTL_BR  = 9'b11111_1100;
   localparam logic [8:0] CTL_FL  = 9'b11111_0100;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [BW-1:0] boot_cnt_r, boot_cnt_s;
   logic [WW-1:0] wait_cnt_r, wait_cnt_s;
   logic [FW-1:0] fl_cnt_r, fl_cnt_s;
   logic          pend_r, pend_s;
   logic          lu_r, lu_s;
   logic          mem_err_r, mem_err_s;
   logic [8:0]    ctl_s;
   logic          mem_stall_s;
   logic          load_use_s;

   assign mem_stall_s = mem_access & ~dmem_ready;
   assign load_use_s  = ex_memread & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           pc_sel_br, flush_front, id_ex_bubble, mem_wb_bubble} = ctl_s;
   assign mem_err = mem_err_r;

   // Next-state and Mealy control outputs
   always_comb begin
      state_s    = state_r;
      boot_cnt_s = boot_cnt_r;
      wait_cnt_s = wait_cnt_r;
      fl_cnt_s   = fl_cnt_r;
      pend_s     = pend_r;
      lu_s       = 1'b0;
      ctl_s      = CTL_OFF;
      case (state_r)
         BOOT: begin
            if (boot_cnt_r == BOOT_LAST) begin
               state_s    = RUN;
               boot_cnt_s = {BW{1'b0}};
            end else begin
               boot_cnt_s = boot_cnt_r + BW'(1);
            end
         end
         RUN: begin
            if (mem_stall_s) begin
               ctl_s      = CTL_MW;
               pend_s     = mem_br_taken;
               wait_cnt_s = WW'(1);
               state_s    = MEM_WAIT;
            end else if (mem_br_taken) begin
               ctl_s = CTL_BR;
               if (FLUSH_CYC > 1) begin
                  state_s  = FLUSH;
                  fl_cnt_s = FW'(1);
               end else begin
                  state_s = RUN;
               end
            end else if (load_use_s && !lu_r) begin
               // lu_r limits the stall to one cycle; ID/EX holds a bubble afterwards
               ctl_s = CTL_LU;
               lu_s  = 1'b1;
            end else begin
               ctl_s = CTL_RUN;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               pend_s     = 1'b0;
               wait_cnt_s = {WW{1'b0}};
               if (pend_r || mem_br_taken) begin
                  ctl_s = CTL_BR;
                  if (FLUSH_CYC > 1) begin
                     state_s  = FLUSH;
                     fl_cnt_s = FW'(1);
                  end else begin
                     state_s = RUN;
                  end
               end else begin
                  ctl_s   = CTL_RUN;
                  state_s = RUN;
               end
            end else begin
               ctl_s      = CTL_MW;
               pend_s     = pend_r | mem_br_taken;
               wait_cnt_s = (wait_cnt_r == MEM_TO_W) ? wait_cnt_r : wait_cnt_r + WW'(1);
            end
         end
         FLUSH: begin
            ctl_s = CTL_FL;
            if (fl_cnt_r >= FLUSH_LAST) begin
               state_s  = RUN;
               fl_cnt_s = {FW{1'b0}};
            end else begin
               fl_cnt_s = fl_cnt_r + FW'(1);
            end
         end
         default: begin
            state_s    = BOOT;
            boot_cnt_s = {BW{1'b0}};
         end
      endcase
      if ((state_s == MEM_WAIT) && (wait_cnt_s == MEM_TO_W)) begin
         mem_err_s = 1'b1;
      end else begin
         mem_err_s = mem_err_r;
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r    <= BOOT;
         boot_cnt_r <= {BW{1'b0}};
         wait_cnt_r <= {WW{1'b0}};
         fl_cnt_r   <= {FW{1'b0}};
         pend_r     <= 1'b0;
         lu_r       <= 1'b0;
         mem_err_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         boot_cnt_r <= boot_cnt_s;
         wait_cnt_r <= wait_cnt_s;
         fl_cnt_r   <= fl_cnt_s;
         pend_r     <= pend_s;
         lu_r       <= lu_s;
         mem_err_r  <= mem_err_s;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Saturating stall and taken-branch counters
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (!pc_en && (state_r != BOOT) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            stall_cnt <= stall_cnt;
         end
         if (pc_sel_br && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end else begin
            flush_cnt <= flush_cnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       arst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs2, ex_memread, mem_access, dmem_ready, mem_br_taken;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       pc_sel_br, flush_front, id_ex_bubble, mem_wb_bubble, mem_err;
`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt, flush_cnt;
`endif

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_br, flush_front, id_ex_bubble, mem_wb_bubble, mem_err}
   localparam logic [9:0] O_BOOT = 10'b00000_0000_0;
   localparam logic [9:0] O_RUN  = 10'b11111_0000_0;
   localparam logic [9:0] O_LU   = 10'b00111_0010_0;
   localparam logic [9:0] O_MW   = 10'b00001_0001_0;
   localparam logic [9:0] O_BR   = 10'b11111_1100_0;
   localparam logic [9:0] O_FL   = 10'b11111_0100_0;
   localparam logic [9:0] O_ERR  = 10'b00000_0000_1;

   pipe_hazard_ctrl #(
      .BOOT_CYC  (4),
      .FLUSH_CYC (2),
      .MEM_TO    (15)
   ) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs2    (id_use_rs2),
      .ex_memread    (ex_memread),
      .ex_rd         (ex_rd),
      .mem_access    (mem_access),
      .dmem_ready    (dmem_ready),
      .mem_br_taken  (mem_br_taken),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .id_ex_en      (id_ex_en),
      .ex_mem_en     (ex_mem_en),
      .mem_wb_en     (mem_wb_en),
      .pc_sel_br     (pc_sel_br),
      .flush_front   (flush_front),
      .id_ex_bubble  (id_ex_bubble),
      .mem_wb_bubble (mem_wb_bubble),
      .mem_err       (mem_err)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt   (stall_cnt)
      , .flush_cnt   (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use2;
      logic       memrd;
      logic [4:0] rd;
      logic       macc;
      logic       rdy;
      logic       br;
      logic [9:0] exp;
   } vec_t;

   vec_t       tbl [11];
   logic [9:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         step_idx = 0;
   string      tag = "init";

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic memrd, input logic [4:0] rd, input logic macc,
                        input logic rdy, input logic br);
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_use_rs2   = use2;
      ex_memread   = memrd;
      ex_rd        = rd;
      mem_access   = macc;
      dmem_ready   = rdy;
      mem_br_taken = br;
   endtask

   task automatic idle();
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic compare_head();
      logic [9:0] got;
      logic [9:0] want;
      got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             pc_sel_br, flush_front, id_ex_bubble, mem_wb_bubble, mem_err};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d got %b expected %b", tag, step_idx, got, want);
      end
      step_idx++;
   endtask

   // expectation queued at drive time, compared on the falling edge
   task automatic step(input logic [9:0] exp);
      exp_q.push_back(exp);
      @(negedge clk);
      compare_head();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input logic [9:0] exp);
      exp_q.push_back(exp);
      compare_head();
   endtask

   task automatic boot_seq();
      tag = "boot";
      step_idx = 0;
      idle();
      for (int i = 0; i < 4; i++) step(O_BOOT);
      step(O_RUN);
   endtask

   initial begin
      //            rs1    rs2    use2  memrd rd     macc  rdy   br    expected
      tbl[0]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[1]  = '{5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, O_LU};
      tbl[2]  = '{5'd5,  5'd2,  1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[3]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[4]  = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, O_LU};
      tbl[5]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[6]  = '{5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[7]  = '{5'd5,  5'd2,  1'b0, 1'b0, 5'd5,  1'b0, 1'b1, 1'b0, O_RUN};
      tbl[8]  = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, O_RUN};
      tbl[9]  = '{5'd9,  5'd2,  1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, O_LU};
      tbl[10] = '{5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, O_RUN};

      arst_n = 1'b0;
      idle();
      #2;
      tag = "reset";
      check_now(O_BOOT);
      repeat (2) @(posedge clk);
      #1;
      arst_n = 1'b1;

      // T1: four cycles with every enable low, then running
      boot_seq();

      // T2 plus assorted single-cycle patterns
      tag = "table";
      step_idx = 0;
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rs1, tbl[i].rs2, tbl[i].use2, tbl[i].memrd, tbl[i].rd,
               tbl[i].macc, tbl[i].rdy, tbl[i].br);
         step(tbl[i].exp);
      end

      // T3: three not-ready cycles then ready
      tag = "memwait";
      step_idx = 0;
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(O_MW);
      dmem_ready = 1'b1;
      step(O_RUN);
      idle();
      step(O_RUN);

      // T4: branch with simultaneous load-use, two flush cycles
      tag = "branch";
      step_idx = 0;
      drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
      step(O_BR);
      step(O_FL);
      idle();
      step(O_RUN);

      // T5: branch arriving while memory stalls is applied on ready
      tag = "deferbr";
      step_idx = 0;
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      step(O_MW);
      mem_br_taken = 1'b0;
      step(O_MW);
      dmem_ready = 1'b1;
      step(O_BR);
      idle();
      step(O_FL);
      step(O_RUN);

      // T6: twenty not-ready cycles; error appears once the wait count hits 15
      tag = "timeout";
      step_idx = 0;
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) step((i >= 16) ? (O_MW | O_ERR) : O_MW);
      dmem_ready = 1'b1;
      step(O_RUN | O_ERR);
      idle();
      step(O_RUN | O_ERR);
      step(O_RUN | O_ERR);

      // reset pulse in the middle of a wait returns to boot and clears the error
      tag = "midreset";
      step_idx = 0;
      drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      step(O_MW | O_ERR);
      step(O_MW | O_ERR);
      #2;
      arst_n = 1'b0;
      #1;
      check_now(O_BOOT);
      idle();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      boot_seq();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
